obs_decoder_score: RTL

Inverse of the obstacle pattern ROM: takes the 7-segment pattern (abcdefg) currently in the hero's digit, decodes it back to its obstacle/bonus code, and checks it against the hero's segment mask. Hits cost a life and bonuses add points. It sits between the scrolling display shifter and the score/HUD logic, and runs once per scroll step.

---
 rtl/obs_decoder_score.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/obs_decoder_score.sv
`default_nettype none
// ============================================================================
// Module   : obs_decoder_score
// Purpose  : Decodes the 7-segment pattern in the hero's digit back into its
//            obstacle/bonus code. Then it checks the pattern against the
//            hero's segment mask. Collisions with obstacles cost a life.
//            Overlapping bonuses add saturating points to the score.
//            One evaluation takes three clock cycles: latch, decode, evaluate.
// Ports    : clk, rst_n (sync, active-low)
//            seg_valid, seg_in[6:0], hero_mask[6:0]  - evaluation request
//            restart                                 - game restart
//            busy, code_valid, obs_code[3:0], hit    - evaluation status
//            bonus_pts[5:0], score[9:0], lives[1:0]  - game state
//            game_over, err                          - status flags
// Revision : 1.0 - initial release
// ============================================================================
module obs_decoder_score #(
    parameter int START_LIVES = 3,
    parameter int SCORE_MAX   = 999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seg_valid,
    input  logic [6:0] seg_in,
    input  logic [6:0] hero_mask,
    input  logic       restart,
    output logic       busy,
    output logic       code_valid,
    output logic [3:0] obs_code,
    output logic       hit,
    output logic [5:0] bonus_pts,
    output logic [9:0] score,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       err
);

    localparam logic [1:0] c_start_lives = 2'(START_LIVES);
    localparam logic [9:0] c_score_max   = 10'(SCORE_MAX);
    localparam logic [3:0] c_code_empty  = 4'd13;
    localparam logic [3:0] c_code_inval  = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EVAL   = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] seg_q, seg_d;
    logic [6:0] mask_q, mask_d;
    logic [3:0] code_q, code_d;
    logic       ov_q, ov_d;
    logic       code_valid_q, code_valid_d;
    logic [3:0] obs_code_q, obs_code_d;
    logic       hit_q, hit_d;
    logic [5:0] bonus_pts_q, bonus_pts_d;
    logic [9:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic       err_q, err_d;

    logic [5:0]  w_pts;
    logic [10:0] w_sum;

    // Inverse of the obstacle pattern ROM (bit6 = a ... bit0 = g).
    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'b0001111: code = 4'd0;
            7'b1100011: code = 4'd1;
            7'b0111000: code = 4'd2;
            7'b0010011: code = 4'd3;
            7'b1000001: code = 4'd4;
            7'b0111111: code = 4'd5;
            7'b0110110: code = 4'd6;
            7'b0010101: code = 4'd7;
            7'b0110001: code = 4'd8;
            7'b1111110: code = 4'd9;
            7'b0110000: code = 4'd10;
            7'b1101101: code = 4'd11;
            7'b1111001: code = 4'd12;
            7'b0000000: code = c_code_empty;
            default:    code = c_code_inval;
        endcase
        return code;
    endfunction

    // Bonus value of the registered code, independent of overlap.
    always_comb begin
        w_pts = 6'd0;
        case (code_q)
            4'd10:   w_pts = 6'd10;
            4'd11:   w_pts = 6'd20;
            4'd12:   w_pts = 6'd30;
            default: w_pts = 6'd0;
        endcase
    end

    // One extra bit keeps the sum from wrapping before the saturation compare.
    assign w_sum = {1'b0, score_q} + {5'b0, w_pts};

    always_comb begin
        state_d      = state_q;
        seg_d        = seg_q;
        mask_d       = mask_q;
        code_d       = code_q;
        ov_d         = ov_q;
        code_valid_d = 1'b0;
        hit_d        = 1'b0;
        obs_code_d   = obs_code_q;
        bonus_pts_d  = bonus_pts_q;
        score_d      = score_q;
        lives_d      = lives_q;
        err_d        = err_q;

        if (restart) begin
            // Restart discards any evaluation in flight.
            state_d     = IDLE;
            score_d     = 10'd0;
            lives_d     = c_start_lives;
            err_d       = 1'b0;
            bonus_pts_d = 6'd0;
            obs_code_d  = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seg_valid) begin
                        seg_d   = seg_in;
                        mask_d  = hero_mask;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    code_d  = decode_seg(seg_q);
                    ov_d    = |(seg_q & mask_q);
                    state_d = EVAL;
                end
                EVAL: begin
                    code_valid_d = 1'b1;
                    obs_code_d   = code_q;
                    bonus_pts_d  = 6'd0;
                    state_d      = IDLE;
                    if (code_q <= 4'd9 && ov_q) begin
                        hit_d = 1'b1;
                        if (lives_q != 2'd0) begin
                            lives_d = lives_q - 2'd1;
                        end
                        if (lives_q <= 2'd1) begin
                            state_d = OVER;
                        end
                    end else if (w_pts != 6'd0 && ov_q) begin
                        bonus_pts_d = w_pts;
                        if (w_sum > {1'b0, c_score_max}) begin
                            score_d = c_score_max;
                        end else begin
                            score_d = w_sum[9:0];
                        end
                    end
                    if (code_q == c_code_inval) begin
                        err_d = 1'b1;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            seg_q        <= 7'd0;
            mask_q       <= 7'd0;
            code_q       <= 4'd0;
            ov_q         <= 1'b0;
            code_valid_q <= 1'b0;
            obs_code_q   <= 4'd0;
            hit_q        <= 1'b0;
            bonus_pts_q  <= 6'd0;
            score_q      <= 10'd0;
            lives_q      <= c_start_lives;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_q        <= seg_d;
            mask_q       <= mask_d;
            code_q       <= code_d;
            ov_q         <= ov_d;
            code_valid_q <= code_valid_d;
            obs_code_q   <= obs_code_d;
            hit_q        <= hit_d;
            bonus_pts_q  <= bonus_pts_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            err_q        <= err_d;
        end
    end

    assign busy       = (state_q == DECODE) || (state_q == EVAL);
    assign game_over  = (state_q == OVER);
    assign code_valid = code_valid_q;
    assign obs_code   = obs_code_q;
    assign hit        = hit_q;
    assign bonus_pts  = bonus_pts_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign err        = err_q;

endmodule
`default_nettype wire
